// File: rtl/fu_result_buffer_pkg.sv
// Shared out-of-order core types: datapath widths and the CDB packet broadcast by each
// functional unit.
package fu_result_buffer_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ROB_TAG_WIDTH = 5;

  typedef struct packed {
    logic [XLEN-1:0]          value;
    logic [ROB_TAG_WIDTH-1:0] tag;
    logic                     exception;
  } cdb_packet_t;

endpackage

// File: rtl/fu_result_buffer_circular_fifo.sv
// Small in-order circular FIFO with synchronous flush; occupancy is tracked by an explicit
// count so full and empty never depend on pointer equality.
module fu_result_buffer_circular_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // Capacity is judged on registered state only: a full buffer refuses even if it pops.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PtrW'(1);
      if (pop_ok)  head_d = head_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/fu_result_buffer.sv
// Per-functional-unit completion buffer feeding the CDB arbiter: requests while non-empty,
// drives the head when granted, pops on a granted broadcast.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int unsigned Xlen     = XLEN,
  parameter int unsigned TagWidth = ROB_TAG_WIDTH,
  parameter int unsigned Depth    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Xlen-1:0]            in_value_i,
  input  logic [TagWidth-1:0]        in_tag_i,
  input  logic                       in_exception_i,
  output logic                       cdb_request_o,
  input  logic                       cdb_grant_i,
  output logic                       cdb_valid_o,
  output logic [Xlen-1:0]            cdb_value_o,
  output logic [TagWidth-1:0]        cdb_tag_o,
  output logic                       cdb_exception_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  typedef struct packed {
    logic [Xlen-1:0]     value;
    logic [TagWidth-1:0] tag;
    logic                exception;
  } packet_t;

  packet_t in_pkt, head_pkt;
  logic    full, empty;

  assign in_pkt = '{value: in_value_i, tag: in_tag_i, exception: in_exception_i};

  fu_result_buffer_circular_fifo #(
    .Width ($bits(packet_t)),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (in_valid_i),
    .data_i  (in_pkt),
    .pop_i   (cdb_valid_o),
    .head_o  (head_pkt),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign in_ready_o      = !full;
  assign cdb_request_o   = !empty;
  // A grant while empty is ignored, so it can never underflow the FIFO.
  assign cdb_valid_o     = cdb_grant_i && cdb_request_o;
  assign cdb_value_o     = head_pkt.value;
  assign cdb_tag_o       = head_pkt.tag;
  assign cdb_exception_o = head_pkt.exception;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the buffer.
module tb_fu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, in_exc;
  logic [31:0] in_value;
  logic [4:0]  in_tag;
  logic        req, grant, cdb_valid, cdb_exc;
  logic [31:0] cdb_value;
  logic [4:0]  cdb_tag;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [37:0] model [$];
  int          pre_size;

  always #5 clk = ~clk;

  fu_result_buffer #(
    .Xlen     (32),
    .TagWidth (5),
    .Depth    (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_value_i      (in_value),
    .in_tag_i        (in_tag),
    .in_exception_i  (in_exc),
    .cdb_request_o   (req),
    .cdb_grant_i     (grant),
    .cdb_valid_o     (cdb_valid),
    .cdb_value_o     (cdb_value),
    .cdb_tag_o       (cdb_tag),
    .cdb_exception_o (cdb_exc),
    .count_o         (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare outputs with the model before the edge.
  task automatic drive(input bit fl, input bit vl, input logic [31:0] val,
                       input logic [4:0] tg, input bit ex, input bit gr);
    @(negedge clk);
    flush = fl; in_valid = vl; in_value = val; in_tag = tg; in_exc = ex; grant = gr;
    #1;
    pre_size = model.size();
    check("count", 64'(count), 64'(pre_size));
    check("in_ready", 64'(in_ready), 64'(pre_size < 4));
    check("request", 64'(req), 64'(pre_size != 0));
    check("cdb_valid", 64'(cdb_valid), 64'(gr && pre_size != 0));
    if (pre_size != 0) check("head", 64'({cdb_value, cdb_tag, cdb_exc}), 64'(model[0]));
  endtask

  task automatic commit();
    @(posedge clk);
    if (flush) model.delete();
    else begin
      if (grant && pre_size != 0) void'(model.pop_front());
      if (in_valid && pre_size < 4) model.push_back({in_value, in_tag, in_exc});
    end
  endtask

  task automatic step(input bit fl, input bit vl, input logic [4:0] tg, input bit gr);
    drive(fl, vl, $urandom, tg, 1'($urandom), gr);
    commit();
  endtask

  typedef struct {
    bit         vl;
    logic [4:0] tg;
    bit         gr;
    int         exp_count;
    bit         exp_req;
    bit         exp_valid;
    logic [4:0] exp_tag;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1, 5'd1, 0, 0, 0, 0, 5'd0};
    vecs[1] = '{1, 5'd2, 0, 1, 1, 0, 5'd1};
    vecs[2] = '{1, 5'd3, 0, 2, 1, 0, 5'd1};
    vecs[3] = '{0, 5'd0, 0, 3, 1, 0, 5'd1};
    vecs[4] = '{0, 5'd0, 1, 3, 1, 1, 5'd1};
    vecs[5] = '{0, 5'd0, 1, 2, 1, 1, 5'd2};
    vecs[6] = '{0, 5'd0, 1, 1, 1, 1, 5'd3};
    vecs[7] = '{0, 5'd0, 0, 0, 0, 0, 5'd0};
    vecs[8] = '{0, 5'd0, 1, 0, 0, 0, 5'd0};
    vecs[9] = '{0, 5'd0, 0, 0, 0, 0, 5'd0};

    rst_n = 1'b0; flush = 0; in_valid = 0; in_value = '0; in_tag = '0; in_exc = 0; grant = 0;
    #2;
    check("reset_count", 64'(count), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_request", 64'(req), 64'(0));
    check("reset_cdb_valid", 64'(cdb_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: push 1,2,3 then drain with grants, then grant while empty.
    foreach (vecs[i]) begin
      drive(0, vecs[i].vl, 32'h100 + i, vecs[i].tg, 0, vecs[i].gr);
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_req", i), 64'(req), 64'(vecs[i].exp_req));
      check($sformatf("vec%0d_valid", i), 64'(cdb_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_count != 0)
        check($sformatf("vec%0d_tag", i), 64'(cdb_tag), 64'(vecs[i].exp_tag));
      commit();
    end

    // Full: tags 8..11, a fifth push refused, one pop reopens in_ready.
    for (int t = 8; t < 12; t++) step(0, 1, 5'(t), 0);
    drive(0, 1, 32'hdead, 5'd12, 0, 0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    commit();
    drive(0, 0, 0, 0, 0, 1);
    check("full_pop_tag", 64'(cdb_tag), 64'(8));
    check("full_count", 64'(count), 64'(4));
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("after_pop_in_ready", 64'(in_ready), 64'(1));
    commit();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);

    // Simultaneous push and pop at count 2 across pointer wrap.
    step(0, 1, 5'd20, 0);
    step(0, 1, 5'd21, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 32'(k), 5'(24 + k), 0, 1);
      check("pp_count", 64'(count), 64'(2));
      check("pp_head", 64'(cdb_tag), 64'(k < 2 ? 20 + k : 22 + k));
      commit();
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Flush at count 3 with a push and a grant in the same cycle.
    for (int t = 1; t < 4; t++) step(0, 1, 5'(t), 0);
    drive(1, 1, 32'h4444, 5'd4, 0, 1);
    check("flush_cdb_valid", 64'(cdb_valid), 64'(1));
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_request", 64'(req), 64'(0));
    commit();

    // Asynchronous reset with 3 entries buffered.
    for (int t = 1; t < 4; t++) step(0, 1, 5'(t), 0);
    @(negedge clk);
    flush = 0; in_valid = 0; grant = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_count", 64'(count), 64'(0));
    check("async_request", 64'(req), 64'(0));
    check("async_in_ready", 64'(in_ready), 64'(1));
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 5'd7, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("post_reset_head", 64'(cdb_tag), 64'(7));
    commit();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(15) == 0), 1'($urandom), 5'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_result_buffer.md
# fu_result_buffer

Per-functional-unit completion buffer sitting directly upstream of the CDB arbiter. It accepts finished results from one functional unit and holds them in a small in-order FIFO. It raises that unit's arbiter request line while non-empty, and drives the head entry onto the CDB source mux when granted. One instance per functional unit; its `cdb_request` is one bit of the arbiter's `request` vector, and the matching `grant` bit returns as `cdb_grant`.

## Interface
- `XLEN`, 32, result value width
- `TAG_WIDTH`, 5, ROB tag width
- `DEPTH`, 4, buffer entries; power of two, ≥ 2

- `clk`  input  1  clock; all state updates on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `flush`  input  1  synchronous squash of all buffered results (mispredict recovery)
- `in_valid`  input  1  functional unit presents a completed result
- `in_ready`  output  1  buffer can accept this cycle
- `in_value`  input  XLEN  result value
- `in_tag`  input  TAG_WIDTH  destination ROB tag
- `in_exception`  input  1  result raised an exception
- `cdb_request`  output  1  to arbiter request bit
- `cdb_grant`  input  1  from arbiter grant bit (combinational, same cycle)
- `cdb_valid`  output  1  this buffer owns the CDB this cycle
- `cdb_value`  output  XLEN  head value
- `cdb_tag`  output  TAG_WIDTH  head tag
- `cdb_exception`  output  1  head exception flag
- `count`  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Clock is `clk`; reset is `reset_n`, asynchronous and active-low. While `reset_n` = 0: head, tail and count = 0; `in_ready` = 1; `cdb_request` = 0; `cdb_valid` = 0. Entry storage need not be reset.
- Push: `in_valid && in_ready` writes {value, tag, exception} at tail. Tail increments mod DEPTH.
- `in_ready` = (count < DEPTH). It depends only on registered state, never on `cdb_grant`. When the buffer is full, no push occurs even if a pop happens that cycle.
- `cdb_request` = (count ≠ 0), registered-state only.
- `cdb_value`/`cdb_tag`/`cdb_exception` always show the head entry. Their value is don't-care when empty.
- `cdb_valid` = `cdb_grant && cdb_request`. A grant while empty is ignored: no pop, and `cdb_valid` = 0.
- Pop: occurs on `cdb_valid`. Head increments mod DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- `flush` = 1: head, tail and count are set to 0 next edge. Flush overrides any push or pop in the same cycle. `cdb_valid` still reflects the current-cycle grant, because the broadcast already occurred.
- No bypass: a result pushed in cycle N is first requestable in cycle N+1.
- Strict FIFO order; results are never reordered or dropped except by flush.

## Timing
- Push-to-request latency: 1 cycle.
- Grant-to-pop: the grant is combinational in cycle N, the pop commits at the edge ending cycle N, and the next entry is visible at the head in cycle N+1.
- Back-to-back grants drain one entry per cycle.
- Full case: with DEPTH entries, `in_ready` = 0. After one pop, `in_ready` = 1 in the following cycle.
- Wrap-around: pointers are `$clog2(DEPTH)` bits and wrap naturally. Full vs empty is distinguished by count, not by pointer equality.
- Reset asserted mid-operation clears the buffer immediately (asynchronous). Outputs take their reset values within the same cycle.

## Structure
- Shared out-of-order package holds:
  - constants `XLEN` and `ROB_TAG_WIDTH`;
  - typedef `cdb_packet_t` (value, tag, exception). The arbiter-side CDB mux reuses this typedef.
- Storage is an array of `cdb_packet_t`.
- One natural sub-module: `circular_fifo`. It is parameterised on width and depth, and provides push/pop/flush, count, and head data. `fu_result_buffer` adds the request/grant handshake around it.

## Test plan
- Reset with `reset_n` = 0 mid-stream holding 3 entries:
  - `count` = 0, `cdb_request` = 0 and `in_ready` = 1 immediately, before the next edge;
  - after release, the next push of tag 7 is the head.
- Push tags 1, 2, 3 on consecutive cycles with `cdb_grant` = 0:
  - `cdb_request` rises the cycle after tag 1 and `count` reaches 3;
  - then grant for 3 cycles: `cdb_tag` = 1, 2, 3 with `cdb_valid` = 1 each cycle, then `count` = 0 and `cdb_request` = 0.
- Fill to DEPTH = 4 with tags 8..11:
  - `in_ready` = 0 and a 5th `in_valid` is not accepted;
  - one grant pops tag 8, and `in_ready` = 1 the next cycle.
- Hold `count` = 2 while asserting push of tag 5 and grant together:
  - `count` stays 2 and the popped tag is the old head;
  - after 8 such cycles with DEPTH = 4 (pointer wrap), order is preserved.
- Hold `count` = 3 and assert `flush` with a simultaneous push of tag 4 and grant:
  - `cdb_valid` = 1 that cycle;
  - next cycle `count` = 0 and tag 4 is not buffered.
- Hold `count` = 0 and drive `cdb_grant` = 1: `cdb_valid` = 0 and `count` stays 0 (no underflow).
